// File: rtl/heap_proto_pkg.sv
// Shared widths, response tags and term constructor tags for the reducer<->heap protocol.
package heap_proto_pkg;
  localparam int ADDR_W = 30;
  localparam int TERM_W = 63;
  localparam int NODE_W = 2 * TERM_W;
  localparam int RESP_W = NODE_W + 2;

  typedef enum logic [1:0] {
    RSP_NONE = 2'b00,
    RSP_READ = 2'b01,
    RSP_WACK = 2'b10,
    RSP_ERR  = 2'b11
  } rsp_tag_e;

  // Constructor tag in term[62:60]; used when building stimulus terms.
  localparam logic [2:0] TAG_NIL = 3'd0;
  localparam logic [2:0] TAG_S   = 3'd1;
  localparam logic [2:0] TAG_K   = 3'd2;
  localparam logic [2:0] TAG_I   = 3'd3;
  localparam logic [2:0] TAG_APP = 3'd4;

  typedef struct packed {
    rsp_tag_e          tag;
    logic [TERM_W-1:0] left;
    logic [TERM_W-1:0] right;
  } heap_resp_t;
endpackage

// File: rtl/heap_node_ram.sv
// Single-port synchronous heap node RAM, write-first, one-cycle read latency.
module heap_node_ram import heap_proto_pkg::*; #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [NODE_W-1:0] wdata,
  output logic [NODE_W-1:0] rdata
);
  logic [NODE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
        rdata     <= wdata;
      end else begin
        rdata     <= mem[addr];
      end
    end
  end
endmodule

// File: rtl/heap_mem_responder.sv
// Heap responder: clears node RAM after reset, then serves read/write requests
// with a registered tag and one-cycle RAM read, holding the response under backpressure.
module heap_mem_responder import heap_proto_pkg::*; #(
  parameter int DEPTH = 1024
) (
  input  logic              system1000,
  input  logic              system1000_rstn,
  input  logic              req_valid_i,
  input  logic              req_write_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [NODE_W-1:0] req_data_i,
  output logic              req_ready_o,
  output logic [RESP_W-1:0] resp_o,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic              err_o
);
  localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {CLEAR, IDLE, RESP} state_e;

  state_e            state, state_nxt;
  rsp_tag_e          tag_q, tag_nxt;
  logic [ADDR_W-1:0] clr_ptr;
  logic              oor, accept;
  logic              ram_en, ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [NODE_W-1:0] ram_wdata, ram_rdata;
  heap_resp_t        resp;

  assign oor = {3'b000, req_addr_i} >= 33'(DEPTH);

  always_comb begin
    state_nxt    = state;
    tag_nxt      = tag_q;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    accept       = 1'b0;
    ram_en       = 1'b0;
    ram_we       = 1'b0;
    ram_addr     = req_addr_i[RAM_AW-1:0];
    ram_wdata    = req_data_i;
    case (state)
      CLEAR: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = clr_ptr[RAM_AW-1:0];
        ram_wdata = '0;
        if (clr_ptr == ADDR_W'(DEPTH - 1)) state_nxt = IDLE;
      end
      IDLE: req_ready_o = 1'b1;
      RESP: begin
        resp_valid_o = 1'b1;
        req_ready_o  = resp_ready_i;
        if (resp_ready_i) begin
          state_nxt = IDLE;
          tag_nxt   = RSP_NONE;
        end
      end
      default: state_nxt = CLEAR;
    endcase
    // A new accept overrides the consume-to-idle path, keeping 1 req/cycle.
    if (req_valid_i && req_ready_o) begin
      accept    = 1'b1;
      state_nxt = RESP;
      ram_en    = !oor;
      ram_we    = req_write_i;
      tag_nxt   = oor ? RSP_ERR : (req_write_i ? RSP_WACK : RSP_READ);
    end
  end

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      state   <= CLEAR;
      tag_q   <= RSP_NONE;
      clr_ptr <= '0;
      err_o   <= 1'b0;
    end else begin
      state <= state_nxt;
      tag_q <= tag_nxt;
      if (state == CLEAR) clr_ptr <= clr_ptr + 1'b1;
      if (accept && oor)  err_o   <= 1'b1;
    end
  end

  heap_node_ram #(.DEPTH(DEPTH), .AW(RAM_AW)) u_ram (
    .clk   (system1000),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // RAM output is only meaningful for read/write-ack; it is stable while no access occurs.
  always_comb begin
    resp.tag = tag_q;
    {resp.left, resp.right} = (tag_q == RSP_READ || tag_q == RSP_WACK) ? ram_rdata : '0;
  end
  assign resp_o = resp;
endmodule
